// File: rtl/product_accumulator.sv
// Accumulates a counted run of 32-bit products into an ACC_W-bit sum with an overflow flag.
// Optional macro ACC_SATURATE_EN: clamp the sum to all ones on overflow instead of wrapping.
module product_accumulator #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_prod,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [SUM_W-1:0] w_sum;
  logic             w_xfer;

  // Extra top bit of the sum is the carry out of the accumulator.
  assign w_sum  = {1'b0, r_acc} + SUM_W'(in_prod);
  assign w_xfer = in_valid & r_in_ready;

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = len;
          w_state_nxt = (len == '0) ? S_OUT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_xfer) begin
          w_cnt_nxt = r_cnt - LEN_W'(1);
          w_ovf_nxt = r_ovf | w_sum[ACC_W];
`ifdef ACC_SATURATE_EN
          // Once clamped, the sum stays pinned at all ones for the rest of the run.
          if (w_sum[ACC_W] || r_ovf) begin
            w_acc_nxt = '1;
          end else begin
            w_acc_nxt = w_sum[ACC_W-1:0];
          end
`else
          w_acc_nxt = w_sum[ACC_W-1:0];
`endif
          if (r_cnt == LEN_W'(1)) begin
            w_state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= (w_state_nxt == S_ACCUM);
      r_out_valid <= (w_state_nxt == S_OUT);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 40-bit and a 32-bit instance driven by shared stimulus.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_prod;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic [39:0] a_out_sum;
  logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [31:0] b_out_sum;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_prod[$];
  bit          q_vpat[$];
  int          valid_pct   = 100;
  int          hold_cycles = 0;
  bit          start_noise = 1'b0;

  int          lat;
  int          irdy_drop;
  int          irdy_seen;
  int          unstable;
  bit          timeout;
  logic        res_irdy_out;
  logic [39:0] res_a_sum;
  logic        res_a_ovf;
  logic [31:0] res_b_sum;
  logic        res_b_ovf;
  logic        post_valid;
  logic        post_busy;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(40), .LEN_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_prod(in_prod), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
    .out_ovf(a_out_ovf), .busy(a_busy)
  );

  product_accumulator #(.ACC_W(32), .LEN_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_prod(in_prod), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
    .out_ovf(b_out_ovf), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic sum of the run, wrapped or clamped at 2^w.
  task automatic model(input int w, input int n, output logic [63:0] s, output logic o);
    longint unsigned acc;
    longint unsigned lim;
    acc = 0;
    lim = 64'd1 << w;
    o   = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + 64'(q_prod[i]);
      if (acc >= lim) begin
        o = 1'b1;
`ifdef ACC_SATURATE_EN
        acc = lim - 1;
`else
        acc = acc - lim;
`endif
      end
    end
    s = acc;
  endtask

  // Drives one full run of n products from q_prod and records what was observed.
  task automatic drive_run(input int n);
    int idx;
    bit v;
    bit xfer;
    start     = 1'b1;
    len       = 8'(n);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    start     = 1'b0;
    lat       = 1;
    idx       = 0;
    irdy_drop = 0;
    irdy_seen = 0;
    while (a_out_valid !== 1'b1 && lat < 500) begin
      if (a_in_ready === 1'b1) irdy_seen++;
      else irdy_drop++;
      if (q_vpat.size() > 0) v = q_vpat.pop_front();
      else v = ($urandom_range(99) < valid_pct);
      in_valid = v && (idx < n);
      in_prod  = in_valid ? q_prod[idx] : $urandom;
      if (start_noise && $urandom_range(3) == 0) begin
        start = 1'b1;
        len   = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      xfer = in_valid;
      step();
      lat++;
      if (xfer) idx++;
    end
    start        = 1'b0;
    in_valid     = 1'b0;
    timeout      = (a_out_valid !== 1'b1);
    res_irdy_out = a_in_ready;
    res_a_sum    = a_out_sum;
    res_a_ovf    = a_out_ovf;
    res_b_sum    = b_out_sum;
    res_b_ovf    = b_out_ovf;
    unstable     = 0;
    for (int k = 0; k < hold_cycles; k++) begin
      start = start_noise;
      len   = 8'($urandom);
      step();
      if (a_out_valid !== 1'b1 || a_out_sum !== res_a_sum || a_out_ovf !== res_a_ovf ||
          b_out_sum !== res_b_sum || b_out_ovf !== res_b_ovf) unstable++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready  = 1'b0;
    post_valid = a_out_valid;
    post_busy  = a_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 8'd3; in_valid = 1'b1; in_prod = 32'd9; out_ready = 1'b0;
    step();
    step();
    checks++;
    if ({a_out_valid, a_in_ready, a_busy, a_out_ovf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags_a: got %b expected 0000", {a_out_valid, a_in_ready, a_busy, a_out_ovf});
    end
    checks++;
    if (a_out_sum !== 40'd0) begin
      errors++;
      $display("FAIL reset_sum_a: got %h expected 0", a_out_sum);
    end
    checks++;
    if ({b_out_valid, b_in_ready, b_busy, b_out_ovf} !== 4'b0000 || b_out_sum !== 32'd0) begin
      errors++;
      $display("FAIL reset_b: got flags %b sum %h expected 0", {b_out_valid, b_in_ready, b_busy, b_out_ovf}, b_out_sum);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [63:0] ms;
    logic        mo;
    q_prod = '{32'd6, 32'hFFFF_FFFF, 32'd10};
    valid_pct = 100; hold_cycles = 0; start_noise = 1'b0;
    drive_run(3);
    checks++;
    if (timeout || lat != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles (timeout=%0d) expected 4", lat, timeout);
    end
    checks++;
    if (res_a_sum !== 40'h01_0000_000F || res_a_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: got %h ovf %b expected 010000000f ovf 0", res_a_sum, res_a_ovf);
    end
    model(32, 3, ms, mo);
    checks++;
    if (res_b_sum !== ms[31:0] || res_b_ovf !== mo) begin
      errors++;
      $display("FAIL basic_sum32: got %h ovf %b expected %h ovf %b", res_b_sum, res_b_ovf, ms[31:0], mo);
    end
    checks++;
    if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: got valid %b busy %b expected 0 0", post_valid, post_busy);
    end
  endtask

  task automatic test_zero_len();
    q_prod = {};
    drive_run(0);
    checks++;
    if (timeout || lat != 1) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles expected 1", lat);
    end
    checks++;
    if (res_a_sum !== 40'd0 || res_a_ovf !== 1'b0 || res_b_sum !== 32'd0) begin
      errors++;
      $display("FAIL zero_sum: got %h / %h expected 0", res_a_sum, res_b_sum);
    end
    checks++;
    if (irdy_seen != 0 || res_irdy_out !== 1'b0) begin
      errors++;
      $display("FAIL zero_in_ready: got %0d ready cycles, ready in OUT %b expected none", irdy_seen, res_irdy_out);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ms;
    logic        mo;
    q_prod = '{$urandom, $urandom};
    q_vpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    hold_cycles = 5;
    drive_run(2);
    hold_cycles = 0;
    q_vpat = {};
    checks++;
    if (irdy_drop != 0 || timeout || lat != 5) begin
      errors++;
      $display("FAIL bp_ready: got %0d drops, latency %0d expected 0 drops, latency 5", irdy_drop, lat);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable);
    end
    model(40, 2, ms, mo);
    checks++;
    if (res_a_sum !== ms[39:0] || res_a_ovf !== mo) begin
      errors++;
      $display("FAIL bp_sum: got %h expected %h", res_a_sum, ms[39:0]);
    end
    checks++;
    if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got valid %b busy %b expected 0 0", post_valid, post_busy);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp32;
`ifdef ACC_SATURATE_EN
    exp32 = 32'hFFFF_FFFF;
`else
    exp32 = 32'd1;
`endif
    q_prod = '{32'hFFFF_FFFF, 32'd2};
    drive_run(2);
    checks++;
    if (res_b_ovf !== 1'b1 || res_b_sum !== exp32) begin
      errors++;
      $display("FAIL ovf32: got %h ovf %b expected %h ovf 1", res_b_sum, res_b_ovf, exp32);
    end
    checks++;
    if (res_a_ovf !== 1'b0 || res_a_sum !== 40'h01_0000_0001) begin
      errors++;
      $display("FAIL ovf40: got %h ovf %b expected 0100000001 ovf 0", res_a_sum, res_a_ovf);
    end
    q_prod = '{32'd1};
    drive_run(1);
    checks++;
    if (res_b_ovf !== 1'b0 || res_b_sum !== 32'd1) begin
      errors++;
      $display("FAIL ovf_clear: got %h ovf %b expected 1 ovf 0", res_b_sum, res_b_ovf);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0; in_valid = 1'b1; in_prod = 32'd7;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    checks++;
    if ({a_busy, a_out_valid, a_in_ready} !== 3'b000 || a_out_sum !== 40'd0) begin
      errors++;
      $display("FAIL abort_state: got busy/valid/ready %b sum %h expected 000 0",
               {a_busy, a_out_valid, a_in_ready}, a_out_sum);
    end
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (a_out_valid !== 1'b0 || a_busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: got %0d active cycles expected 0", seen);
    end
    q_prod = '{32'd5};
    drive_run(1);
    checks++;
    if (timeout || res_a_sum !== 40'd5 || res_a_ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_run: got %h expected 5", res_a_sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    p = $urandom;
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0; in_valid = 1'b1; in_prod = $urandom;
    step();
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_valid: got %b expected 1", a_out_valid);
    end
    out_ready = 1'b1; start = 1'b1; len = 8'd1;
    step();
    checks++;
    if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handshake_start: got busy %b valid %b expected 0 0", a_busy, a_out_valid);
    end
    out_ready = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_next_start: got busy %b ready %b expected 1 1", a_busy, a_in_ready);
    end
    in_valid = 1'b1; in_prod = p;
    step();
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 40'(p)) begin
      errors++;
      $display("FAIL b2b_second_sum: got valid %b sum %h expected 1 %h", a_out_valid, a_out_sum, p);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] ma;
    logic [63:0] mb;
    logic        oa;
    logic        ob;
    int          n;
    start_noise = 1'b1;
    for (int it = 0; it < 40; it++) begin
      n = (it % 8 == 7) ? $urandom_range(20, 60) : $urandom_range(0, 10);
      q_prod = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(2))
          0:       q_prod.push_back($urandom);
          1:       q_prod.push_back(32'hFFFF_FF00 | 32'($urandom_range(255)));
          default: q_prod.push_back(32'($urandom_range(255)));
        endcase
      end
      valid_pct   = (it % 4 == 0) ? 100 : $urandom_range(30, 99);
      hold_cycles = $urandom_range(0, 3);
      drive_run(n);
      model(40, n, ma, oa);
      model(32, n, mb, ob);
      checks++;
      if (timeout || (valid_pct == 100 && lat != n + 1)) begin
        errors++;
        $display("FAIL rnd%0d_latency: got %0d cycles (timeout=%0d) len %0d", it, lat, timeout, n);
      end
      checks++;
      if (res_a_sum !== ma[39:0] || res_a_ovf !== oa) begin
        errors++;
        $display("FAIL rnd%0d_sum40: got %h ovf %b expected %h ovf %b", it, res_a_sum, res_a_ovf, ma[39:0], oa);
      end
      checks++;
      if (res_b_sum !== mb[31:0] || res_b_ovf !== ob) begin
        errors++;
        $display("FAIL rnd%0d_sum32: got %h ovf %b expected %h ovf %b", it, res_b_sum, res_b_ovf, mb[31:0], ob);
      end
      checks++;
      if (unstable != 0 || irdy_drop != 0 || post_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_protocol: got unstable %0d drops %0d post_valid %b expected 0 0 0",
                 it, unstable, irdy_drop, post_valid);
      end
    end
    start_noise = 1'b0;
    valid_pct   = 100;
    hold_cycles = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_overflow();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
